// File: rtl/fp_addsub_align.sv
// rtl/fp_addsub_align.sv - binary32 add/sub front end: specials, operand swap, alignment, significand add/sub
// Two handshaked register stages feeding the normalize/round stage.
module fp_addsub_align (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op,
   input  logic [2:0]  rm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        S_G,
   output logic        Co,
   output logic        eq,
   output logic [7:0]  E_S,
   output logic [27:0] M_S,
   output logic [2:0]  R_M,
   output logic        spec,
   output logic [31:0] spec_res
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // ---------------- stage 1: unpack, specials, swap ----------------
   logic [7:0]  ea, eb, ea_eff, eb_eff;
   logic [22:0] fa, fb;
   logic        sb_eff, sub;
   logic        a_nan, b_nan, a_inf, b_inf;
   logic        a_ge, mag_eq, eq_c;
   logic        sp_c;
   logic [31:0] sp_res_c;
   logic        sign_c;

   assign ea     = a[30:23];
   assign eb     = b[30:23];
   assign fa     = a[22:0];
   assign fb     = b[22:0];
   assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
   assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
   assign sb_eff = b[31] ^ op;
   assign sub    = a[31] ^ sb_eff;
   assign a_nan  = (&ea) & (|fa);
   assign b_nan  = (&eb) & (|fb);
   assign a_inf  = (&ea) & ~(|fa);
   assign b_inf  = (&eb) & ~(|fb);
   assign a_ge   = a[30:0] >= b[30:0];
   assign mag_eq = a[30:0] == b[30:0];
   assign eq_c   = sub & mag_eq;
   // Exact cancel takes its sign from the rounding mode (-0 only under round-down).
   assign sign_c = eq_c ? (rm == 3'b010) : (a_ge ? a[31] : sb_eff);

   always_comb begin
      sp_c     = 1'b0;
      sp_res_c = 32'd0;
      if (a_nan | b_nan) begin
         sp_c     = 1'b1;
         sp_res_c = QNAN;
      end else if (a_inf & b_inf & sub) begin
         sp_c     = 1'b1;
         sp_res_c = QNAN;
      end else if (a_inf) begin
         sp_c     = 1'b1;
         sp_res_c = {a[31], 8'hFF, 23'd0};
      end else if (b_inf) begin
         sp_c     = 1'b1;
         sp_res_c = {sb_eff, 8'hFF, 23'd0};
      end
   end

   logic        s1_valid, s1_spec, s1_sign, s1_sub, s1_eq;
   logic [31:0] s1_spec_res;
   logic [7:0]  s1_exp, s1_d;
   logic [23:0] s1_lman, s1_sman;
   logic [2:0]  s1_rm;
   logic        s2_adv;

   assign s2_adv   = ~out_valid | out_ready;
   assign in_ready = ~s1_valid | s2_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_spec     <= 1'b0;
         s1_spec_res <= 32'd0;
         s1_sign     <= 1'b0;
         s1_sub      <= 1'b0;
         s1_eq       <= 1'b0;
         s1_exp      <= 8'd0;
         s1_d        <= 8'd0;
         s1_lman     <= 24'd0;
         s1_sman     <= 24'd0;
         s1_rm       <= 3'd0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_spec     <= sp_c;
            s1_spec_res <= sp_res_c;
            s1_sign     <= sign_c;
            s1_sub      <= sub;
            s1_eq       <= eq_c;
            s1_rm       <= rm;
            s1_exp      <= a_ge ? ea_eff : eb_eff;
            s1_d        <= a_ge ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
            s1_lman     <= a_ge ? {|ea, fa} : {|eb, fb};
            s1_sman     <= a_ge ? {|eb, fb} : {|ea, fa};
         end
      end
   end

   // ---------------- stage 2: align and add/subtract ----------------
   logic [53:0] wide;
   logic [27:0] aligned, l28, diff28;
   logic [28:0] sum29;

   // Top 27 bits are the shifted significand plus the first three shifted-out bits;
   // everything below collapses into sticky.
   assign wide    = {s1_sman, 30'd0} >> s1_d;
   assign aligned = (s1_d >= 8'd27) ? {27'd0, |s1_sman} : {wide[53:27], |wide[26:0]};
   assign l28     = {s1_lman, 4'd0};
   assign sum29   = {1'b0, l28} + {1'b0, aligned};
   assign diff28  = l28 - aligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         S_G       <= 1'b0;
         Co        <= 1'b0;
         eq        <= 1'b0;
         E_S       <= 8'd0;
         M_S       <= 28'd0;
         R_M       <= 3'd0;
         spec      <= 1'b0;
         spec_res  <= 32'd0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            spec     <= s1_spec;
            spec_res <= s1_spec_res;
            R_M      <= s1_rm;
            if (s1_spec) begin
               S_G <= 1'b0;
               Co  <= 1'b0;
               eq  <= 1'b0;
               E_S <= 8'd0;
               M_S <= 28'd0;
            end else if (s1_eq) begin
               S_G <= s1_sign;
               Co  <= 1'b0;
               eq  <= 1'b1;
               E_S <= s1_exp;
               M_S <= 28'd0;
            end else if (s1_sub) begin
               S_G <= s1_sign;
               Co  <= 1'b0;
               eq  <= 1'b0;
               E_S <= s1_exp;
               M_S <= diff28;
            end else begin
               S_G       <= s1_sign;
               {Co, M_S} <= sum29;
               eq        <= 1'b0;
               E_S       <= s1_exp;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_addsub_align.sv
// tb/tb_fp_addsub_align.sv - directed-vector bench for fp_addsub_align
module tb_fp_addsub_align;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        op = 1'b0;
   logic [2:0]  rm = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        S_G, Co, eq, spec;
   logic [7:0]  E_S;
   logic [27:0] M_S;
   logic [2:0]  R_M;
   logic [31:0] spec_res;

   int tests = 0;
   int fails = 0;

   fp_addsub_align dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
      .S_G(S_G), .Co(Co), .eq(eq), .E_S(E_S), .M_S(M_S), .R_M(R_M),
      .spec(spec), .spec_res(spec_res)
   );

   always #5 clk = ~clk;

   function automatic logic [74:0] got();
      return {spec, spec_res, S_G, Co, eq, E_S, M_S, R_M};
   endfunction

   function automatic logic [74:0] mk(input logic sp, input logic [31:0] sr, input logic sg,
                                      input logic co, input logic e, input logic [7:0] es,
                                      input logic [27:0] ms, input logic [2:0] r);
      return {sp, sr, sg, co, e, es, ms, r};
   endfunction

   task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                        input logic [2:0] vrm, output logic [74:0] res, output int lat);
      @(negedge clk);
      a = va; b = vb; op = vop; rm = vrm; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      for (int i = 0; i < 20 && !in_ready; i++) begin
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      res = got();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if ({out_valid, in_ready, got()} !== {1'b0, 1'b1, 75'd0}) begin
         fails++;
         $display("FAIL reset got valid=%b ready=%b fields=%h want valid=0 ready=1 fields=0",
                  out_valid, in_ready, got());
      end
   endtask

   task automatic test_add_sub();
      logic [31:0] va [4], vb [4];
      logic        vop [4];
      logic [2:0]  vrm [4];
      logic [74:0] ve [4];
      logic [74:0] r;
      int          l;
      va = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h3F800000};
      vb = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3FC00000};
      vop = '{1'b0, 1'b0, 1'b1, 1'b1};
      vrm = '{3'd0, 3'd1, 3'd0, 3'd0};
      ve[0] = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 8'h7F, 28'h0000000, 3'd0);
      ve[1] = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 8'h7F, 28'h4000000, 3'd1);
      ve[2] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h7F, 28'h4000000, 3'd0);
      ve[3] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 8'h7F, 28'h4000000, 3'd0);
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], vop[i], vrm[i], r, l);
         tests++;
         if (r !== ve[i] || l != 2) begin
            fails++;
            $display("FAIL add_sub[%0d] got=%h lat=%0d want=%h lat=2", i, r, l, ve[i]);
         end
      end
   endtask

   task automatic test_cancel_zero();
      logic [31:0] va [4], vb [4];
      logic        vop [4];
      logic [2:0]  vrm [4];
      logic [74:0] ve [4];
      logic [74:0] r;
      int          l;
      va = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000};
      vb = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000};
      vop = '{1'b1, 1'b1, 1'b0, 1'b1};
      vrm = '{3'd0, 3'd2, 3'd0, 3'd0};
      ve[0] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h7F, 28'h0, 3'd0);
      ve[1] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 8'h7F, 28'h0, 3'd2);
      ve[2] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 8'h01, 28'h0, 3'd0);
      ve[3] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h01, 28'h0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], vop[i], vrm[i], r, l);
         tests++;
         if (r !== ve[i] || l != 2) begin
            fails++;
            $display("FAIL cancel_zero[%0d] got=%h lat=%0d want=%h lat=2", i, r, l, ve[i]);
         end
      end
   endtask

   task automatic test_align();
      logic [31:0] va [5], vb [5];
      logic        vop [5];
      logic [74:0] ve [5];
      logic [74:0] r;
      int          l;
      va = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000001, 32'h3F800000};
      vb = '{32'h30800000, 32'h33800000, 32'h00000001, 32'h00000001, 32'h30800000};
      vop = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ve[0] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h7F, 28'h8000001, 3'd0);
      ve[1] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h7F, 28'h8000008, 3'd0);
      ve[2] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h7F, 28'h8000001, 3'd0);
      ve[3] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h01, 28'h0000020, 3'd0);
      ve[4] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h7F, 28'h7FFFFFF, 3'd0);
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], vop[i], 3'd0, r, l);
         tests++;
         if (r !== ve[i] || l != 2) begin
            fails++;
            $display("FAIL align[%0d] got=%h lat=%0d want=%h lat=2", i, r, l, ve[i]);
         end
      end
   endtask

   task automatic test_special();
      logic [31:0] va [5], vb [5];
      logic        vop [5];
      logic [2:0]  vrm [5];
      logic [74:0] ve [5];
      logic [74:0] r;
      int          l;
      va = '{32'h7F800000, 32'h7F800000, 32'hFFC00001, 32'h3F800000, 32'h7F800000};
      vb = '{32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000};
      vop = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vrm = '{3'd0, 3'd0, 3'd3, 3'd5, 3'd1};
      ve[0] = mk(1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 8'h00, 28'h0, 3'd0);
      ve[1] = mk(1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b0, 8'h00, 28'h0, 3'd0);
      ve[2] = mk(1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 8'h00, 28'h0, 3'd3);
      ve[3] = mk(1'b1, 32'hFF800000, 1'b0, 1'b0, 1'b0, 8'h00, 28'h0, 3'd5);
      ve[4] = mk(1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b0, 8'h00, 28'h0, 3'd1);
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], vop[i], vrm[i], r, l);
         tests++;
         if (r !== ve[i] || l != 2) begin
            fails++;
            $display("FAIL special[%0d] got=%h lat=%0d want=%h lat=2", i, r, l, ve[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [4], vb [4];
      logic        vop [4];
      logic [2:0]  vrm [4];
      logic [74:0] ve [4];
      int          in_idx = 0;
      int          out_idx = 0;
      va = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h7F800000};
      vb = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h3F800000};
      vop = '{1'b0, 1'b1, 1'b1, 1'b0};
      vrm = '{3'd0, 3'd3, 3'd1, 3'd4};
      ve[0] = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 8'h7F, 28'h0000000, 3'd0);
      ve[1] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h7F, 28'h4000000, 3'd3);
      ve[2] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 8'h7F, 28'h4000000, 3'd1);
      ve[3] = mk(1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b0, 8'h00, 28'h0, 3'd4);
      @(negedge clk);
      for (int cyc = 0; cyc < 12; cyc++) begin
         out_ready = 1'b1;
         if (in_idx < 4) begin
            a = va[in_idx]; b = vb[in_idx]; op = vop[in_idx]; rm = vrm[in_idx]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) begin
            tests++;
            if (out_idx >= 4 || got() !== ve[out_idx] || cyc != out_idx + 2) begin
               fails++;
               $display("FAIL b2b[%0d] cyc=%0d got=%h want=%h at cyc %0d",
                        out_idx, cyc, got(), ve[out_idx % 4], out_idx + 2);
            end
            out_idx++;
         end
         if (in_valid && in_ready) in_idx++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (out_idx != 4 || in_idx != 4) begin
         fails++;
         $display("FAIL b2b_count got in=%0d out=%0d want 4/4", in_idx, out_idx);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] va [3], vb [3];
      logic        vop [3];
      logic [2:0]  vrm [3];
      logic [74:0] ve [3];
      int          in_idx = 0;
      int          out_idx = 0;
      va = '{32'h3F800000, 32'h3FC00000, 32'h7F800000};
      vb = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
      vop = '{1'b0, 1'b1, 1'b0};
      vrm = '{3'd0, 3'd3, 3'd4};
      ve[0] = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 8'h7F, 28'h0000000, 3'd0);
      ve[1] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h7F, 28'h4000000, 3'd3);
      ve[2] = mk(1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b0, 8'h00, 28'h0, 3'd4);
      @(negedge clk);
      for (int cyc = 0; cyc < 14; cyc++) begin
         out_ready = (cyc >= 6);
         if (in_idx < 3) begin
            a = va[in_idx]; b = vb[in_idx]; op = vop[in_idx]; rm = vrm[in_idx]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc == 2) begin
            tests++;
            if (in_ready !== 1'b0 || in_idx != 2) begin
               fails++;
               $display("FAIL bp_full got ready=%b accepted=%0d want ready=0 accepted=2", in_ready, in_idx);
            end
         end
         if (cyc == 5) begin
            tests++;
            if (out_valid !== 1'b1 || got() !== ve[0]) begin
               fails++;
               $display("FAIL bp_hold got valid=%b %h want valid=1 %h", out_valid, got(), ve[0]);
            end
         end
         if (out_valid && out_ready) begin
            tests++;
            if (out_idx >= 3 || got() !== ve[out_idx] || cyc != out_idx + 6) begin
               fails++;
               $display("FAIL bp_out[%0d] cyc=%0d got=%h want=%h at cyc %0d",
                        out_idx, cyc, got(), ve[out_idx % 3], out_idx + 6);
            end
            out_idx++;
         end
         if (in_valid && in_ready) in_idx++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (out_idx != 3 || in_idx != 3) begin
         fails++;
         $display("FAIL bp_count got in=%0d out=%0d want 3/3", in_idx, out_idx);
      end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; rm = 3'd0; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || got() !== 75'd0) begin
         fails++;
         $display("FAIL rst_mid got valid=%b ready=%b fields=%h want 0/1/0", out_valid, in_ready, got());
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (out_valid) seen++;
         @(negedge clk);
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL rst_flush got %0d emitted want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_cancel_zero();
      test_align();
      test_special();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
